// File: rtl/regfile_sb_pkg.sv
// Shared CPU definitions for the register file: default widths, the x0 index,
// and the packed-port slicing macro used by regfile_sb and sb_scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).

`ifndef REGFILE_SB_PKG_MACROS
`define REGFILE_SB_PKG_MACROS
// Select element k of width w from a packed multi-port bus.
`define RF_SLICE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int NREGS_DEF = 1 << AW_DEF;

  // Index of the hardwired-zero register.
  localparam int REG_ZERO  = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard and decode stall reduction.
// A register goes busy when a writer issues and clears when that write retires;
// an issue in the same cycle as a retire to the same register wins (newer producer).

module sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = AW_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_vld,
  input  logic [AW-1:0]        issue_rd,
  input  logic                 w_en,
  input  logic [AW-1:0]        rd_id,
  input  logic [NUM_RD*AW-1:0] rs_id,
  input  logic [NUM_RD-1:0]    rs_used,
  input  logic [NUM_RD-1:0]    bypass_hit,
  output logic [NREGS-1:0]     busy,
  output logic                 stall
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: issue sets, retire clears, issue takes priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (issue_vld && issue_rd == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if (w_en && rd_id == AW'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy register with synchronous reset; reset drops any same-cycle issue or retire.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Stall while any consumed source is busy and not satisfied by forwarding.
  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rs_used[k] && !bypass_hit[k] && busy_q[`RF_SLICE(rs_id, k, AW)]) begin
        stall = 1'b1;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one synchronous write port,
// x0 hardwired to zero, and a busy scoreboard driving the decode stall.
// Optional feature macro: REGFILE_BYPASS_EN -- a retiring write is forwarded to
// any read port naming the same register in the same cycle, and clears that port's stall.

module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = AW_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_id_i,
  input  logic [NUM_RD-1:0]      rs_used_i,
  output logic [NUM_RD*XLEN-1:0] rs_rdata_o,
  input  logic                   w_en,
  input  logic [AW-1:0]          rd_id_i,
  input  logic [XLEN-1:0]        rd_write_data_i,
  input  logic                   issue_vld_i,
  input  logic [AW-1:0]          issue_rd_i,
  output logic                   stall_o,
  output logic [NREGS-1:0]       busy_o
);

  logic [XLEN-1:0]   regs [NREGS];
  logic [NUM_RD-1:0] bypass_hit;
  logic              wr_valid;

  assign wr_valid = w_en && (rd_id_i != AW'(REG_ZERO));

  // Register storage: cleared by reset, written on the edge; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is reset because software may read any register before writing it;
      // this forces flops rather than a RAM macro, which is acceptable at this size.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[rd_id_i] <= rd_write_data_i;
    end
  end

  // Read ports: x0 returns zero; with forwarding, a same-index retiring write wins.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] stored;

    assign idx    = `RF_SLICE(rs_id_i, k, AW);
    assign stored = (idx == AW'(REG_ZERO)) ? '0 : regs[idx];

`ifdef REGFILE_BYPASS_EN
    assign bypass_hit[k]                     = wr_valid && (rd_id_i == idx);
    assign `RF_SLICE(rs_rdata_o, k, XLEN) = bypass_hit[k] ? rd_write_data_i : stored;
`else
    assign bypass_hit[k]                     = 1'b0;
    assign `RF_SLICE(rs_rdata_o, k, XLEN) = stored;
`endif
  end

  sb_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_vld  (issue_vld_i),
    .issue_rd   (issue_rd_i),
    .w_en       (w_en),
    .rd_id      (rd_id_i),
    .rs_id      (rs_id_i),
    .rs_used    (rs_used_i),
    .bypass_hit (bypass_hit),
    .busy       (busy_o),
    .stall      (stall_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (NUM_RD=3, XLEN=64).
// A behavioural model (register array + busy array) is compared against the DUT
// on every falling edge; directed steps also check hand-computed literals.

module tb_regfile_sb;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rs_id;
  logic [NUM_RD-1:0]      rs_used;
  logic [NUM_RD*XLEN-1:0] rs_rdata;
  logic                   w_en;
  logic [AW-1:0]          rd_id;
  logic [XLEN-1:0]        wdata;
  logic                   issue_vld;
  logic [AW-1:0]          issue_rd;
  logic                   stall;
  logic [NREGS-1:0]       busy;

  int  total = 0;
  int  bad   = 0;
  bit  chk_en = 1'b0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  regfile_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rs_id_i         (rs_id),
    .rs_used_i       (rs_used),
    .rs_rdata_o      (rs_rdata),
    .w_en            (w_en),
    .rd_id_i         (rd_id),
    .rd_write_data_i (wdata),
    .issue_vld_i     (issue_vld),
    .issue_rd_i      (issue_rd),
    .stall_o         (stall),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] port(input int k);
    logic [NUM_RD*XLEN-1:0] v;
    v = rs_rdata;
    return v[k*XLEN +: XLEN];
  endfunction

  // Model state: architectural registers and outstanding producers.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      if (w_en && rd_id != 0) begin
        m_regs[rd_id] <= wdata;
        m_busy[rd_id] <= 1'b0;
      end
      if (issue_vld && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
    end
  end

  // Compare DUT outputs against the model every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_stall;
      exp_stall = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
        logic [AW-1:0]   id;
        logic [XLEN-1:0] exp_d;
        logic            hit;
        id  = rs_id[k*AW +: AW];
        hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
        hit = w_en && rd_id != 0 && rd_id == id;
`endif
        exp_d = hit ? wdata : (id == 0 ? '0 : m_regs[id]);
        if (rs_used[k] && m_busy[id] && !hit) exp_stall = 1'b1;
        check($sformatf("cmp_rdata%0d", k), port(k), exp_d);
      end
      check("cmp_stall", 64'(stall), 64'(exp_stall));
      check("cmp_busy", 64'(busy), 64'(m_busy));
    end
  end

  task automatic idle();
    rst = 1'b0; w_en = 1'b0; rd_id = '0; wdata = '0;
    issue_vld = 1'b0; issue_rd = '0; rs_id = '0; rs_used = '0;
  endtask

  task automatic set_rs(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] c, input logic [NUM_RD-1:0] used);
    rs_id = {c, b, a};
    rs_used = used;
  endtask

  // Let the current inputs take effect at one rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // 1. Reset clears registers and discards same-cycle write/issue.
    w_en = 1'b1; rd_id = 5; wdata = 64'hDEAD;
    tick();
    idle(); set_rs(5, 0, 0, 3'b001);
    #1 check("t1_x5_written", port(0), 64'hDEAD);
    rst = 1'b1; w_en = 1'b1; rd_id = 6; wdata = 64'h77; issue_vld = 1'b1; issue_rd = 8;
    tick();
    idle(); set_rs(5, 6, 8, 3'b111);
    #1;
    check("t1_x5_after_rst", port(0), 64'h0);
    check("t1_x6_discarded", port(1), 64'h0);
    check("t1_busy_after_rst", 64'(busy), 64'h0);
    check("t1_stall_after_rst", 64'(stall), 64'h0);

    // 2. Write/read, x0 guard.
    w_en = 1'b1; rd_id = 3; wdata = 64'h1234_5678;
    tick();
    w_en = 1'b1; rd_id = 0; wdata = 64'hFFFF;
    set_rs(3, 0, 0, 3'b000);
    #1 check("t2_x3", port(0), 64'h1234_5678);
    tick();
    idle(); set_rs(0, 3, 0, 3'b000);
    #1;
    check("t2_x0_zero", port(0), 64'h0);
    check("t2_x3_port1", port(1), 64'h1234_5678);

    // 3. Hazard on x7, cleared by retire.
    issue_vld = 1'b1; issue_rd = 7;
    tick();
    idle(); set_rs(7, 0, 0, 3'b001);
    #1 check("t3_stall_busy", 64'(stall), 64'h1);
    w_en = 1'b1; rd_id = 7; wdata = 64'hAB;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("t3_stall_write_cycle", 64'(stall), 64'h0);
    check("t3_rdata_write_cycle", port(0), 64'hAB);
`else
    check("t3_stall_write_cycle", 64'(stall), 64'h1);
    check("t3_rdata_write_cycle", port(0), 64'h0);
`endif
    tick();
    idle(); set_rs(7, 0, 0, 3'b001);
    #1;
    check("t3_stall_after", 64'(stall), 64'h0);
    check("t3_x7", port(0), 64'hAB);

    // 4. Issue vs retire priority.
    issue_vld = 1'b1; issue_rd = 9; w_en = 1'b1; rd_id = 9; wdata = 64'h55;
    tick();
    idle();
    #1 check("t4_busy9_issue_wins", 64'(busy), 64'h200);
    issue_vld = 1'b1; issue_rd = 4; w_en = 1'b1; rd_id = 9; wdata = 64'h66;
    tick();
    idle();
    #1 check("t4_busy4_not9", 64'(busy), 64'h10);

    // 5. Unused operands never stall; issue to x0 does nothing.
    issue_vld = 1'b1; issue_rd = 2;
    tick();
    issue_vld = 1'b1; issue_rd = 0;
    tick();
    idle(); set_rs(0, 2, 0, 3'b001);
    #1;
    check("t5_busy_x0_ignored", 64'(busy), 64'h14);
    check("t5_unused_no_stall", 64'(stall), 64'h0);
    rs_used = 3'b010;
    #1 check("t5_used_port1_stall", 64'(stall), 64'h1);
    set_rs(0, 0, 2, 3'b100);
    #1 check("t5_used_port2_stall", 64'(stall), 64'h1);

    // 6. Three 64-bit ports return their own slices; top register boundary.
    idle();
    w_en = 1'b1; rd_id = 1; wdata = 64'h1111_2222_3333_4444;
    tick();
    w_en = 1'b1; rd_id = 2; wdata = 64'h5555_6666_7777_8888;
    tick();
    w_en = 1'b1; rd_id = 3; wdata = 64'h9999_AAAA_BBBB_CCCC;
    tick();
    w_en = 1'b1; rd_id = 31; wdata = 64'hFEDC_BA98_7654_3210;
    tick();
    idle(); set_rs(1, 2, 3, 3'b111);
    #1;
    check("t6_port0_x1", port(0), 64'h1111_2222_3333_4444);
    check("t6_port1_x2", port(1), 64'h5555_6666_7777_8888);
    check("t6_port2_x3", port(2), 64'h9999_AAAA_BBBB_CCCC);
    check("t6_no_stall", 64'(stall), 64'h0);
    check("t6_busy_x2_cleared", 64'(busy), 64'h10);
    set_rs(31, 0, 31, 3'b101);
    #1;
    check("t6_x31_port0", port(0), 64'hFEDC_BA98_7654_3210);
    check("t6_x31_port2", port(2), 64'hFEDC_BA98_7654_3210);
    tick();
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the decode-stage register file, for the pipelined core.
- Provides NUM_RD combinational read ports, one synchronous write port, and x0 hardwired to zero.
- Adds a per-register busy scoreboard: a register is marked busy when an instruction that writes it issues, and cleared when that write retires.
- Raises a decode stall while any used source operand is busy.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; must be a power of 2, ≥2
- AW, 5, register index width; must equal log2(NREGS)
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rs_id_i  in  NUM_RD*AW  packed source indices; port k uses bits [k*AW +: AW]
- rs_used_i  in  NUM_RD  bit k=1 means port k's operand is actually consumed
- rs_rdata_o  out  NUM_RD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN]
- w_en  in  1  writeback enable
- rd_id_i  in  AW  writeback destination index
- rd_write_data_i  in  XLEN  writeback data
- issue_vld_i  in  1  instruction leaves decode this cycle and will write a register
- issue_rd_i  in  AW  destination of the issuing instruction
- stall_o  out  1  at least one used source is busy
- busy_o  out  NREGS  scoreboard vector, for debug and the hazard unit

Behaviour:
- Reset (rst=1 at a clock edge):
  - all registers become 0 and busy becomes 0.
  - A reset asserted mid-operation discards any pending writes and issues in that cycle.
  - Outputs after reset: rs_rdata_o=0, busy_o=0, stall_o=0.
- Write: when w_en=1 and rd_id_i≠0, the register takes rd_write_data_i at the edge. Writes to x0 are ignored.
- Read: combinational. rs_id=0 always returns 0. Without the bypass feature, a write is visible from the cycle after the edge.
- Scoreboard next state, per register r≠0, evaluated in this order:
  - if issue_vld_i and issue_rd_i==r, set busy[r]=1 (issue wins over a same-cycle retire to the same register, because it represents a newer producer);
  - else if w_en and rd_id_i==r, clear busy[r]=0;
  - else hold.
- busy[0] is constantly 0. issue_rd_i=0 has no effect.
- Stall: stall_o = OR over k of (rs_used_i[k] & busy[rs_id_k] & ~bypass_hit_k).
  - Without the bypass feature, bypass_hit_k=0.
  - Unused ports (rs_used_i[k]=0) never stall.
- The scoreboard supports one outstanding producer per register. Issuing again to a register that is already busy keeps it busy; preventing WAW hazards is the issuing logic's responsibility.
- There is no internal pipeline latency: stall_o is combinational from the inputs and the registered busy vector.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If w_en=1, rd_id_i≠0 and rd_id_i==rs_id_k, then rs_rdata_o for port k is rd_write_data_i, and bypass_hit_k=1 (the retiring value satisfies the operand, so no stall on that port).
- Undefined: no forwarding. The read returns the old value and the stall is held until the cycle after the write.

Decomposition:
- Shared package or header, in cpu_defs:
  - XLEN/AW defaults
  - the REG_ZERO index constant
  - the packed-port slicing macros
- One natural sub-module: sb_scoreboard, holding the busy vector, its set/clear logic and the stall reduction.
- Storage and the read muxes stay in regfile_sb.

Test Plan:
1. Reset: write x5=0xDEAD, then assert rst for one cycle → next cycle rs0=5 reads 0, busy_o=0, stall_o=0.
2. Write/read with x0 guard: w_en, rd=3, data 0x1234_5678 → next cycle x3 reads 0x12345678. A write of 0xFFFF to x0 → x0 reads 0.
3. Scoreboard hazard: issue rd=7, then next cycle rs0=7 with rs_used=01 → stall_o=1. Write rd=7 with data 0xAB → without the feature, stall_o=0 from the following cycle and x7 reads 0xAB. With REGFILE_BYPASS_EN, stall_o=0 and rs0 data=0xAB in the write cycle itself.
4. Simultaneous issue and retire to x9 → busy_o[9]=1 after the edge. Simultaneous issue to x4 and retire to x9 → busy[4]=1, busy[9]=0.
5. Unused operand: busy[2]=1, rs1=2 with rs_used=01 → stall_o=0. Set rs_used=10 → stall_o=1.
6. NUM_RD=3, XLEN=64: drive distinct rs_ids 1, 2, 3 with known contents → each packed slice returns its own 64-bit value.
